// File: rtl/load_store_unit.sv
// Load/store unit: turns a single core memory request into one word-aligned
// memory transaction and stalls the core until it completes.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   lsu_req_i         core requests a memory access this instruction
//   lsu_we_i          1 = store, 0 = load
//   lsu_size_i        000 B, 001 H, 010 W, 100 BU, 101 HU
//   lsu_addr_i        byte address
//   lsu_data_i        store data
//   lsu_data_o        extended load result (held until the next load)
//   lsu_stall_o       core must hold PC and inputs while high
//   lsu_err_o         one-cycle pulse on a misaligned or illegal access
//   data_req_o        memory request
//   data_we_o         memory write enable
//   data_be_o         byte enables
//   data_addr_o       word-aligned address
//   data_wdata_o      lane-replicated write data
//   data_rdata_i      memory read word
//   data_rvalid_i     memory completion (read data valid / write accepted)
module load_store_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lsu_req_i,
    input  logic         lsu_we_i,
    input  logic [2:0]   lsu_size_i,
    input  logic [N-1:0] lsu_addr_i,
    input  logic [N-1:0] lsu_data_i,
    output logic [N-1:0] lsu_data_o,
    output logic         lsu_stall_o,
    output logic         lsu_err_o,
    output logic         data_req_o,
    output logic         data_we_o,
    output logic [3:0]   data_be_o,
    output logic [N-1:0] data_addr_o,
    output logic [N-1:0] data_wdata_o,
    input  logic [N-1:0] data_rdata_i,
    input  logic         data_rvalid_i
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic         we_q, we_d;
    logic [2:0]   size_q, size_d;
    logic [1:0]   off_q, off_d;
    logic [N-1:0] addr_q, addr_d;
    logic [3:0]   be_q, be_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] ldata_q, ldata_d;

    logic         legal;
    logic [3:0]   be_new;
    logic [N-1:0] wdata_new;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;
    logic [N-1:0] load_ext;

    // Access legality: alignment, reserved size codes, unsigned stores.
    always_comb begin
        legal = 1'b0;
        case (lsu_size_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~lsu_addr_i[0];
            3'b010:  legal = (lsu_addr_i[1:0] == 2'b00);
            3'b100:  legal = ~lsu_we_i;
            3'b101:  legal = ~lsu_we_i & ~lsu_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated write data; size[1:0] covers B/BU, H/HU, W.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << lsu_addr_i[1:0];
                wdata_new = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_new = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = lsu_data_i;
            end
        endcase
    end

    // Load extraction uses the latched offset, not the live address.
    always_comb begin
        case (off_q)
            2'b00:   rd_byte = data_rdata_i[7:0];
            2'b01:   rd_byte = data_rdata_i[15:8];
            2'b10:   rd_byte = data_rdata_i[23:16];
            default: rd_byte = data_rdata_i[31:24];
        endcase
        rd_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (size_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = data_rdata_i;
        endcase
    end

    // Next-state and outputs.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        ldata_d     = ldata_q;
        lsu_stall_o = 1'b0;
        lsu_err_o   = 1'b0;
        data_req_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (lsu_req_i) begin
                    if (legal) begin
                        lsu_stall_o = 1'b1;
                        we_d        = lsu_we_i;
                        size_d      = lsu_size_i;
                        off_d       = lsu_addr_i[1:0];
                        addr_d      = {lsu_addr_i[N-1:2], 2'b00};
                        be_d        = be_new;
                        wdata_d     = wdata_new;
                        state_d     = StBusy;
                    end else begin
                        lsu_err_o = 1'b1;
                    end
                end
            end
            StBusy: begin
                lsu_stall_o = 1'b1;
                data_req_o  = 1'b1;
                if (data_rvalid_i) begin
                    if (!we_q) begin
                        ldata_d = load_ext;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data_we_o    = data_req_o & we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;
    assign lsu_data_o   = ldata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        data_rvalid_i;

    int errors = 0;
    int checks = 0;

    // Observations collected by run_txn.
    int          obs_stall;
    int          obs_busy;
    int          obs_err;
    bit          obs_req_bad;
    bit          obs_unstable;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic [31:0] obs_ldata;

    load_store_unit #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_size_i   (lsu_size_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_data_i   (lsu_data_i),
        .lsu_data_o   (lsu_data_o),
        .lsu_stall_o  (lsu_stall_o),
        .lsu_err_o    (lsu_err_o),
        .data_req_o   (data_req_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i),
        .data_rvalid_i(data_rvalid_i)
    );

    always #5 clk = ~clk;

    // Present one request and hold it until stall drops (or the bound runs out).
    // Memory returns rvalid in busy cycle number waits+1.
    task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits);
        obs_stall    = 0;
        obs_busy     = 0;
        obs_err      = 0;
        obs_req_bad  = 0;
        obs_unstable = 0;
        obs_addr     = '0;
        obs_be       = '0;
        obs_wdata    = '0;
        obs_we       = 1'b0;
        @(posedge clk);
        #1;
        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_size_i   = size;
        lsu_addr_i   = addr;
        lsu_data_i   = wd;
        data_rdata_i = rd;
        for (int cyc = 0; cyc < 30; cyc++) begin
            data_rvalid_i = (cyc == waits + 1);
            @(negedge clk);
            if (lsu_err_o) obs_err++;
            if (data_req_o && !lsu_stall_o) obs_req_bad = 1;
            if (data_req_o) begin
                if (obs_busy == 0) begin
                    obs_addr  = data_addr_o;
                    obs_be    = data_be_o;
                    obs_wdata = data_wdata_o;
                    obs_we    = data_we_o;
                end else if (data_addr_o !== obs_addr || data_be_o !== obs_be ||
                             data_wdata_o !== obs_wdata || data_we_o !== obs_we) begin
                    obs_unstable = 1;
                end
                obs_busy++;
            end
            if (!lsu_stall_o) break;
            obs_stall++;
            @(posedge clk);
            #1;
        end
        obs_ldata     = lsu_data_o;
        data_rvalid_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_size_i    = 3'b000;
        lsu_addr_i    = '0;
        lsu_data_i    = '0;
        data_rdata_i  = '0;
        data_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({lsu_data_o, lsu_stall_o, lsu_err_o, data_req_o, data_we_o, data_be_o,
             data_addr_o, data_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h stall=%b err=%b req=%b we=%b be=%b addr=%h wd=%h, want all 0",
                     lsu_data_o, lsu_stall_o, lsu_err_o, data_req_o, data_we_o, data_be_o,
                     data_addr_o, data_wdata_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_busy();
        @(posedge clk);
        #1;
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_0040;
        @(posedge clk);
        #1;
        checks++;
        if (data_req_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_req_before_reset: got %b want 1", data_req_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (data_req_o !== 1'b0 || lsu_stall_o !== 1'b0 && lsu_req_i === 1'b0) begin
            errors++;
            $display("FAIL reset_in_busy_req: req=%b want 0", data_req_o);
        end
        lsu_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        data_rdata_i  = 32'hCAFE_F00D;
        data_rvalid_i = 1'b1;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({lsu_data_o, lsu_stall_o, lsu_err_o, data_req_o, data_we_o, data_be_o,
             data_addr_o, data_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_in_busy_outputs: data=%h stall=%b req=%b be=%b addr=%h, want all 0",
                     lsu_data_o, lsu_stall_o, data_req_o, data_be_o, data_addr_o);
        end
    endtask

    task automatic test_lw();
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        checks++;
        if (obs_addr !== 32'h0000_0100 || obs_be !== 4'b1111 || obs_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_request: addr=%h be=%b we=%b want 00000100 1111 0",
                     obs_addr, obs_be, obs_we);
        end
        checks++;
        if (obs_stall != 2) begin
            errors++;
            $display("FAIL lw_stall: got %0d want 2", obs_stall);
        end
        checks++;
        if (obs_ldata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw_data: got %h want deadbeef", obs_ldata);
        end
        idle_cycle();
    endtask

    task automatic test_sub_word_loads();
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        checks++;
        if (obs_ldata !== 32'hFFFF_FF80 || obs_be !== 4'b1000) begin
            errors++;
            $display("FAIL lb_sign: data=%h be=%b want ffffff80 1000", obs_ldata, obs_be);
        end
        idle_cycle();
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        checks++;
        if (obs_ldata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_zero: got %h want 00000080", obs_ldata);
        end
        idle_cycle();
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_1234, 1);
        checks++;
        if (obs_ldata !== 32'hFFFF_80FF || obs_be !== 4'b1100 || obs_stall != 3) begin
            errors++;
            $display("FAIL lh_upper: data=%h be=%b stall=%0d want ffff80ff 1100 3",
                     obs_ldata, obs_be, obs_stall);
        end
        idle_cycle();
        run_txn(1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_9ABC, 0);
        checks++;
        if (obs_ldata !== 32'h0000_9ABC || obs_be !== 4'b0011) begin
            errors++;
            $display("FAIL lhu_lower: data=%h be=%b want 00009abc 0011", obs_ldata, obs_be);
        end
        idle_cycle();
    endtask

    task automatic test_stores();
        run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3);
        checks++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1 ||
            obs_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sh_request: be=%b wd=%h we=%b addr=%h want 1100 abcdabcd 1 00000200",
                     obs_be, obs_wdata, obs_we, obs_addr);
        end
        checks++;
        if (obs_stall != 5 || obs_busy != 4 || obs_unstable) begin
            errors++;
            $display("FAIL sh_latency: stall=%0d busy=%0d unstable=%0d want 5 4 0",
                     obs_stall, obs_busy, obs_unstable);
        end
        // A store must leave the previous load result in place.
        checks++;
        if (obs_ldata !== 32'h0000_9ABC) begin
            errors++;
            $display("FAIL store_keeps_load: got %h want 00009abc", obs_ldata);
        end
        idle_cycle();
        run_txn(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 0);
        checks++;
        if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5 || obs_we !== 1'b1) begin
            errors++;
            $display("FAIL sb_request: be=%b wd=%h we=%b want 0010 a5a5a5a5 1",
                     obs_be, obs_wdata, obs_we);
        end
        idle_cycle();
        @(negedge clk);
        checks++;
        if (data_we_o !== 1'b0 || data_req_o !== 1'b0) begin
            errors++;
            $display("FAIL we_outside_req: we=%b req=%b want 0 0", data_we_o, data_req_o);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  sz [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
        logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ads [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
        for (int i = 0; i < 4; i++) begin
            run_txn(wes[i], sz[i], ads[i], 32'h0, 32'h0, 0);
            checks++;
            if (obs_err != 1 || obs_stall != 0 || obs_busy != 0) begin
                errors++;
                $display("FAIL illegal_%0d: err=%0d stall=%0d busy=%0d want 1 0 0",
                         i, obs_err, obs_stall, obs_busy);
            end
            idle_cycle();
            @(negedge clk);
            checks++;
            if (lsu_err_o !== 1'b0 || data_req_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_after_%0d: err=%b req=%b want 0 0", i, lsu_err_o, data_req_o);
            end
        end
    endtask

    task automatic test_stray_rvalid();
        @(posedge clk);
        #1;
        data_rdata_i  = 32'h1111_2222;
        data_rvalid_i = 1'b1;
        repeat (2) @(negedge clk);
        data_rvalid_i = 1'b0;
        checks++;
        if (lsu_data_o !== 32'h0000_9ABC || data_req_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_rvalid: data=%h req=%b stall=%b want 00009abc 0 0",
                     lsu_data_o, data_req_o, lsu_stall_o);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h0BAD_CAFE, 0);
        checks++;
        if (obs_stall != 2 || obs_req_bad || obs_ldata !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL b2b_first: stall=%0d overlap=%0d data=%h want 2 0 0badcafe",
                     obs_stall, obs_req_bad, obs_ldata);
        end
        run_txn(1'b1, 3'b010, 32'h0000_0004, 32'h7777_8888, 32'h0, 0);
        checks++;
        if (obs_stall != 2 || obs_req_bad || obs_addr !== 32'h0000_0004 || obs_we !== 1'b1 ||
            obs_wdata !== 32'h7777_8888) begin
            errors++;
            $display("FAIL b2b_second: stall=%0d overlap=%0d addr=%h we=%b wd=%h want 2 0 00000004 1 77778888",
                     obs_stall, obs_req_bad, obs_addr, obs_we, obs_wdata);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_reset_in_busy();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_illegal();
        test_stray_rvalid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
